// File: rtl/apb_master.sv
// APB initiator: buffers valid/ready requests in a small FIFO and runs each one
// as an APB SETUP/ACCESS transfer. Define APB_MASTER_PREADY_EN for slave wait states.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_write,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
`ifdef APB_MASTER_PREADY_EN
  input  logic                  pready,
`endif
  input  logic [DATA_WIDTH-1:0] prdata
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  req_t            fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop, empty, access_done;
  req_t            head;

  assign req_ready = (count != CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = req_valid && req_ready;
  assign head      = fifo_mem[rd_ptr];

`ifdef APB_MASTER_PREADY_EN
  assign access_done = pready;
`else
  assign access_done = 1'b1;
`endif

  assign psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable = (state_q == ACCESS);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = SETUP;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (access_done) state_d = RESP;
      RESP: if (rsp_ready) begin
        // next request goes straight to SETUP without an idle bubble
        if (!empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // address/data registers only change on a pop, so they hold while psel=0
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (pop) begin
      pwrite <= head.write;
      paddr  <= head.addr;
      pwdata <= head.write ? head.wdata : '0;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_write <= 1'b0;
    end else if (state_q == ACCESS && access_done) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= pwrite ? '0 : prdata;
      rsp_write <= pwrite;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of single transfers plus
// backpressure, streaming, wait-state and mid-transfer reset sequences.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        slave_rdy;
  logic        tb_clr;
  logic [31:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 pclk = ~pclk;

`ifdef APB_MASTER_PREADY_EN
  logic pready;
  assign slave_rdy = pready;
  assign prdata    = pready ? mem[paddr] : 32'hBAD0_BAD0;
`else
  assign slave_rdy = 1'b1;
  assign prdata    = mem[paddr];
`endif

  // simple register-file slave
  always @(posedge pclk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (psel && penable && pwrite && slave_rdy) begin
      mem[paddr] <= pwdata;
    end
  end

  apb_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_write(rsp_write),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_MASTER_PREADY_EN
    .pready(pready),
`endif
    .prdata(prdata)
  );

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // caller is #1 after an edge; returns #1 after the accepting edge
  task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("push_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    logic        s_w [4];
    logic [31:0] s_d [4];
    logic [31:0] s_exp [4];

    vecs[0] = '{1'b1, 8'h00, 32'h0000_0001, 32'h0};
    vecs[1] = '{1'b0, 8'h00, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0};
    vecs[3] = '{1'b0, 8'h10, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 32'h0};
    vecs[5] = '{1'b0, 8'hFF, 32'h0,         32'hFFFF_FFFF};
    vecs[6] = '{1'b0, 8'h20, 32'h1234_5678, 32'h0};

    presetn = 1'b0; tb_clr = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
`ifdef APB_MASTER_PREADY_EN
    pready = 1'b1;
`endif
    tick(); tick(); tick();

    // ---- reset state ----
    chk("rst_psel", 32'(psel), 0);
    chk("rst_penable", 32'(penable), 0);
    chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_paddr", 32'(paddr), 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    presetn = 1'b1; tb_clr = 1'b0;
    tick();
    chk("rst_req_ready", 32'(req_ready), 1);

    // ---- table of single transfers ----
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      chk("v_idle_psel", 32'(psel), 0);
      tick();
      chk("v_setup_psel", 32'(psel), 1);
      chk("v_setup_penable", 32'(penable), 0);
      chk("v_setup_paddr", 32'(paddr), 32'(vecs[i].addr));
      chk("v_setup_pwrite", 32'(pwrite), 32'(vecs[i].write));
      chk("v_setup_pwdata", pwdata, vecs[i].write ? vecs[i].wdata : 32'h0);
      tick();
      chk("v_access_psel", 32'(psel), 1);
      chk("v_access_penable", 32'(penable), 1);
      chk("v_access_paddr", 32'(paddr), 32'(vecs[i].addr));
      chk("v_access_rsp_valid", 32'(rsp_valid), 0);
      tick();
      chk("v_resp_psel", 32'(psel), 0);
      chk("v_rsp_valid", 32'(rsp_valid), 1);
      chk("v_rsp_write", 32'(rsp_write), 32'(vecs[i].write));
      chk("v_rsp_rdata", rsp_rdata, vecs[i].exp_rdata);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("v_rsp_clear", 32'(rsp_valid), 0);
      chk("v_idle_after", 32'(psel), 0);
    end

    // ---- backpressure: three requests, response parked ----
    push(1'b1, 8'h30, 32'h11);
    push(1'b0, 8'h30, 32'h0);
    push(1'b1, 8'h31, 32'h22);
    tick();
    chk("bp_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_rsp_write", 32'(rsp_write), 1);
    chk("bp_rsp_rdata", rsp_rdata, 0);
    chk("bp_psel", 32'(psel), 0);
    chk("bp_full", 32'(req_ready), 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h32; req_wdata = 32'h33;
    tick(); tick();
    chk("bp_stall", 32'(req_ready), 0);
    chk("bp_hold_valid", 32'(rsp_valid), 1);
    chk("bp_hold_write", 32'(rsp_write), 1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_b_setup_psel", 32'(psel), 1);
    chk("bp_b_setup_pen", 32'(penable), 0);
    chk("bp_b_paddr", 32'(paddr), 32'h30);
    chk("bp_b_pwrite", 32'(pwrite), 0);
    chk("bp_b_pwdata", pwdata, 0);
    chk("bp_rsp_cleared", 32'(rsp_valid), 0);
    chk("bp_ready_again", 32'(req_ready), 1);
    tick(); tick();
    chk("bp_b_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_b_rdata", rsp_rdata, 32'h11);
    chk("bp_b_write", 32'(rsp_write), 0);
    tick();
    chk("bp_c_direct_setup", 32'(psel), 1);
    chk("bp_c_setup_pen", 32'(penable), 0);
    chk("bp_c_paddr", 32'(paddr), 32'h31);
    chk("bp_c_pwdata", pwdata, 32'h22);
    tick(); tick();
    chk("bp_c_rsp_valid", 32'(rsp_valid), 1);
    chk("bp_c_write", 32'(rsp_write), 1);
    chk("bp_c_rdata", rsp_rdata, 0);
    tick();
    chk("bp_idle_psel", 32'(psel), 0);
    chk("bp_idle_rsp", 32'(rsp_valid), 0);

    // ---- streaming: alternating writes/reads, rsp_ready high ----
    s_w[0] = 1'b1; s_d[0] = 32'hA5; s_exp[0] = 32'h0;
    s_w[1] = 1'b0; s_d[1] = 32'h0;  s_exp[1] = 32'hA5;
    s_w[2] = 1'b1; s_d[2] = 32'h5A; s_exp[2] = 32'h0;
    s_w[3] = 1'b0; s_d[3] = 32'h0;  s_exp[3] = 32'h5A;
    fork
      begin
        for (int k = 0; k < 4; k++) push(s_w[k], 8'h00, s_d[k]);
      end
      begin
        int n = 0;
        while (!psel && n < 20) begin
          tick();
          n++;
        end
        chk("st_start_timeout", 32'(psel), 1);
        for (int k = 0; k < 12; k++) begin
          chk("st_psel", 32'(psel), (k % 3 != 2) ? 32'd1 : 32'd0);
          if (k % 3 == 2) begin
            chk("st_rsp_valid", 32'(rsp_valid), 1);
            chk("st_rsp_write", 32'(rsp_write), 32'(s_w[k/3]));
            chk("st_rsp_rdata", rsp_rdata, s_exp[k/3]);
          end
          tick();
        end
        chk("st_end_psel", 32'(psel), 0);
        chk("st_end_rsp", 32'(rsp_valid), 0);
      end
    join
    rsp_ready = 1'b0;

`ifdef APB_MASTER_PREADY_EN
    // ---- wait states: pready low for three ACCESS cycles ----
    pready = 1'b0;
    push(1'b0, 8'h30, 32'h0);
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      chk("pr_wait_penable", 32'(penable), 1);
      chk("pr_wait_paddr", 32'(paddr), 32'h30);
      chk("pr_wait_rsp", 32'(rsp_valid), 0);
      tick();
    end
    chk("pr_last_access", 32'(penable), 1);
    pready = 1'b1;
    tick();
    chk("pr_rsp_valid", 32'(rsp_valid), 1);
    chk("pr_rdata", rsp_rdata, 32'h11);
    chk("pr_psel_drop", 32'(psel), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    // ---- reset during ACCESS with a request still queued ----
    push(1'b1, 8'h40, 32'h77);
    push(1'b0, 8'h40, 32'h0);
    tick();
    chk("mr_in_access", 32'(penable), 1);
    #2 presetn = 1'b0;
    #1;
    chk("mr_psel", 32'(psel), 0);
    chk("mr_penable", 32'(penable), 0);
    chk("mr_rsp_valid", 32'(rsp_valid), 0);
    tick();
    presetn = 1'b1;
    chk("mr_req_ready", 32'(req_ready), 1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mr_no_rsp", 32'(rsp_valid), 0);
      chk("mr_no_psel", 32'(psel), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
